dmem_sync_ctrl: RTL and testbench
=================================

Name: dmem_sync_ctrl

Overview:
- Synchronous, parametrised byte-addressable big-endian data memory with a valid/ready request port and a valid/ready response port.
- Serves the MEM stage of the pipelined MIPS core.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Read/write latency is configurable and fixed, there is exactly one request outstanding, and it detects reserved-size accesses and, optionally, misaligned accesses.

Parameters:
DEPTH, 512, memory size in bytes; must be a power of two, at least 4
ADDR_WIDTH, $clog2(DEPTH), byte address width
DATA_WIDTH, 32, data port width; fixed at 32
LATENCY, 1, cycles from request accept to response valid; legal range 1..4

Ports:
clk  in  1  clock; all state changes on the rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_sext  in  1  load sign-extend enable; ignored for word accesses and stores
req_addr  in  ADDR_WIDTH  byte address of the most significant byte
req_wdata  in  32  store data, right-justified (byte=[7:0], half=[15:0])
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts the response
resp_rdata  out  32  load result; 0 for stores and faults
resp_fault  out  1  access was rejected; memory is unchanged

Behaviour:
- Reset and FSM:
  - States: IDLE, WAIT, RESP.
  - Reset (asynchronous, any state) forces IDLE, latency counter 0, resp_valid 0, resp_rdata 0, resp_fault 0.
  - Memory array is not reset; contents are undefined until written.
  - An access in flight when reset asserts is discarded. A store commits only if its accept edge occurred before reset asserted.
- IDLE:
  - req_ready = 1 only in IDLE.
  - A handshake (req_valid & req_ready at the clock edge) latches the request.
  - Store: bytes are written at that same edge.
  - Load: bytes are read from the array as it stands after that edge.
  - Next state: WAIT if LATENCY > 1, else RESP.
- WAIT: counter increments each cycle. Move to RESP after LATENCY-1 further cycles, so resp_valid rises exactly LATENCY cycles after the accept edge.
- RESP:
  - resp_valid = 1. resp_rdata and resp_fault are held stable until resp_valid & resp_ready.
  - On that handshake, go to IDLE and clear resp_valid.
  - No back-to-back accept in the handshake cycle: the minimum request spacing is LATENCY+1 cycles.
- Byte ordering is big-endian: byte at addr is the MSB.
  - Half = {M[a], M[a+1]}.
  - Word = {M[a], M[a+1], M[a+2], M[a+3]}.
  - Byte address arithmetic wraps modulo DEPTH. For example, a word at DEPTH-2 uses bytes DEPTH-2, DEPTH-1, 0, 1.
- Load extension:
  - Byte: sext ? {24{b[7]}} : 24'b0, concatenated with the byte.
  - Half: sext ? {16{h[15]}} : 16'b0, concatenated with the half.
  - Word: unaffected by sext.
- Reserved size 11: always a fault. No write; resp_rdata = 0; resp_fault = 1; normal latency.
- Stores: resp_rdata = 0 and resp_fault = 0 unless faulted. The response acts as the store acknowledge.
- req_* inputs are don't-care when not handshaking.
- Changes to req_* after the accept edge have no effect.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- When defined:
  - A half at an odd address, or a word with addr[1:0] != 00, is a fault.
  - No bytes are written; resp_rdata = 0; resp_fault = 1; the response arrives at normal latency.
- When undefined:
  - Misaligned accesses proceed byte-wise with modulo-DEPTH wrap.
  - resp_fault is raised only for size 11.

Decomposition:
- Package dmem_pkg holds:
  - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11;
  - FSM state encoding ST_IDLE, ST_WAIT, ST_RESP;
  - the maximum LATENCY constant (4).
- One sub-module, dmem_byte_array:
  - DEPTH x 8 storage;
  - a 4-lane byte write with per-lane enable and wrapped lane addresses;
  - a 4-lane combinational read.
- The controller does the FSM, alignment/fault logic, lane steering and extension.

Test Plan:
- LATENCY=1:
  - Store word 0xDEADBEEF at 0x10, then load word at 0x10.
  - Required: rdata=0xDEADBEEF.
  - Byte loads 0x10..0x13 return 0xDE, 0xAD, 0xBE, 0xEF.
  - resp_valid rises exactly 1 cycle after each accept.
- Sign/zero extension:
  - Byte 0x80 at 0x20, half 0x8001 at 0x22.
  - Byte load with sext=1 gives 0xFFFFFF80; with sext=0 gives 0x00000080.
  - Half load with sext=1 gives 0xFFFF8001; with sext=0 gives 0x00008001.
- Backpressure, LATENCY=3:
  - Hold resp_ready=0 for 5 cycles after resp_valid.
  - Required: rdata stable, req_ready=0 throughout; the next request is accepted only in the cycle after the response handshake.
- Faults:
  - size=11 store of 0x12345678 at 0x30 returns fault=1; a subsequent word load at 0x30 still returns the prior contents.
  - With DMEM_ALIGN_CHECK_EN: word store at 0x31 gives fault=1, memory unchanged.
  - Without the macro: the same store writes 0x31..0x34.
- Wrap, without DMEM_ALIGN_CHECK_EN:
  - Word store 0xA1B2C3D4 at 510 (DEPTH=512).
  - Required: byte 510=0xA1, 511=0xB2, 0=0xC3, 1=0xD4.
- Reset mid-operation:
  - Assert reset_n=0 while in WAIT (LATENCY=4).
  - Required: resp_valid=0 immediately (asynchronously), state IDLE, req_ready=1 after release, no spurious response.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_sync_ctrl shared types: access sizes, FSM states, limits.
// Load extension helper used by the controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int MAX_LATENCY = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Pick the loaded bytes out of a big-endian 4-byte window and extend.
  function automatic logic [31:0] load_ext(
    input logic [1:0]  size,
    input logic        sext,
    input logic [31:0] win
  );
    logic [31:0] r;
    r = 32'h0;
    unique case (size)
      SZ_BYTE: r = {{24{sext & win[31]}}, win[31:24]};
      SZ_HALF: r = {{16{sext & win[31]}}, win[31:16]};
      SZ_WORD: r = win;
      SZ_RSVD: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_sync_ctrl_if.sv
// dmem_sync_ctrl request/response bus.
// Valid/ready on both the request and the response side.
interface dmem_sync_ctrl_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_sext;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_fault;

  modport master (
    output req_valid, req_write, req_size, req_sext,
    output req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_size, req_sext,
    input  req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/dmem_byte_array.sv
// DEPTH x 8 storage with a 4-lane wrapped byte window.
// Lane 0 is the byte at addr_i and maps to the MSB of the window.
module dmem_byte_array #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] lane_a [4];

  // Lane addresses wrap naturally at the power-of-two depth.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_a[i] = addr_i + AW'(i);
    end
  end

  assign rdata_o = {mem_q[lane_a[0]], mem_q[lane_a[1]],
                    mem_q[lane_a[2]], mem_q[lane_a[3]]};

  // Per-lane byte writes; the array itself is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[lane_a[i]] <= wdata_i[31-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_sync_ctrl.sv
// Big-endian synchronous data memory, fixed latency, one outstanding.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned half/word accesses.
module dmem_sync_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input logic           clk,
  input logic           reset_n,
  dmem_sync_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    fault_q, fault_d;

  logic        acc;
  logic        misal;
  logic        flt;
  logic [3:0]  lane_we;
  logic [3:0]  we;
  logic [31:0] wword;
  logic [31:0] rword;
  logic [31:0] ld;

  assign acc = bus.req_valid && (state_q == ST_IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
  // Halves need an even address, words a 4-byte boundary.
  always_comb begin
    misal = 1'b0;
    unique case (bus.req_size)
      SZ_HALF: misal = bus.req_addr[0];
      SZ_WORD: misal = |bus.req_addr[1:0];
      default: misal = 1'b0;
    endcase
  end
`else
  assign misal = 1'b0;
`endif

  assign flt = (bus.req_size == SZ_RSVD) || misal;

  // Left-justify store data onto the lanes and pick lane enables.
  always_comb begin
    lane_we = 4'b0000;
    wword   = 32'h0;
    unique case (bus.req_size)
      SZ_BYTE: begin
        lane_we = 4'b0001;
        wword   = {bus.req_wdata[7:0], 24'h0};
      end
      SZ_HALF: begin
        lane_we = 4'b0011;
        wword   = {bus.req_wdata[15:0], 16'h0};
      end
      SZ_WORD: begin
        lane_we = 4'b1111;
        wword   = bus.req_wdata;
      end
      SZ_RSVD: begin
        lane_we = 4'b0000;
        wword   = 32'h0;
      end
    endcase
  end

  assign we = (acc && bus.req_write && !flt) ? lane_we : 4'b0000;
  assign ld = load_ext(bus.req_size, bus.req_sext, rword);

  dmem_byte_array #(
    .DEPTH (DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .we_i    (we),
    .addr_i  (bus.req_addr),
    .wdata_i (wword),
    .rdata_o (rword)
  );

  // Next state, latency count and latched response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          state_d = (LATENCY > 1) ? ST_WAIT : ST_RESP;
          cnt_d   = CNT_W'(1);
          rdata_d = (bus.req_write || flt) ? '0 : ld;
          fault_d = flt;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAT_M1) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and response registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;

endmodule

// File: tb/tb_dmem_sync_ctrl.sv
// Bench for dmem_sync_ctrl: three instances at LATENCY 1, 3 and 4.
// Vector table on the LATENCY=1 copy, hand sequences for the rest.
module tb_dmem_sync_ctrl;
  import dmem_pkg::*;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic clk;
  logic reset_n;

  logic        rv  [3];
  logic        rw  [3];
  logic [1:0]  rsz [3];
  logic        rsx [3];
  logic [8:0]  ra  [3];
  logic [31:0] rwd [3];
  logic        rr  [3];

  logic        o_ready [3];
  logic        o_valid [3];
  logic [31:0] o_rdata [3];
  logic        o_fault [3];

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    dmem_sync_ctrl_if #(.ADDR_WIDTH(9)) b ();
    assign b.req_valid  = rv[g];
    assign b.req_write  = rw[g];
    assign b.req_size   = rsz[g];
    assign b.req_sext   = rsx[g];
    assign b.req_addr   = ra[g];
    assign b.req_wdata  = rwd[g];
    assign b.resp_ready = rr[g];
    assign o_ready[g]   = b.req_ready;
    assign o_valid[g]   = b.resp_valid;
    assign o_rdata[g]   = b.resp_rdata;
    assign o_fault[g]   = b.resp_fault;
    dmem_sync_ctrl #(
      .DEPTH   (512),
      .LATENCY (L)
    ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sx;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ef;
  } vec_t;

  vec_t tv [40];
  int   nv = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic add(input logic w, input logic [1:0] sz,
                     input logic sx, input logic [8:0] a,
                     input logic [31:0] wd, input logic [31:0] er,
                     input logic ef);
    tv[nv].w  = w;
    tv[nv].sz = sz;
    tv[nv].sx = sx;
    tv[nv].a  = a;
    tv[nv].wd = wd;
    tv[nv].er = er;
    tv[nv].ef = ef;
    nv++;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Wait for req_ready, present one request, return #1 after accept edge.
  task automatic accept(input int k, input logic w, input logic [1:0] sz,
                        input logic sx, input logic [8:0] a,
                        input logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready[k]) chk("ready_timeout", 32'(o_ready[k]), 32'd1);
    rv[k]  = 1'b1;
    rw[k]  = w;
    rsz[k] = sz;
    rsx[k] = sx;
    ra[k]  = a;
    rwd[k] = wd;
    @(posedge clk);
    #1;
    rv[k]  = 1'b0;
    rwd[k] = 32'hxxxxxxxx;
    ra[k]  = 9'h1ff;
  endtask

  // Called #1 after the accept edge; counts edges to resp_valid.
  task automatic collect(input int k, output logic [31:0] rd,
                         output logic ft, output int lat);
    lat = 1;
    while (!o_valid[k] && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!o_valid[k]) chk("resp_timeout", 32'(o_valid[k]), 32'd1);
    rd = o_rdata[k];
    ft = o_fault[k];
    rr[k] = 1'b1;
    @(posedge clk);
    #1;
    rr[k] = 1'b0;
    chk("vdrop", 32'(o_valid[k]), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic        ft;
  int          lat;
  int          spur;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rv[k] = 1'b0; rw[k] = 1'b0; rsz[k] = 2'b00; rsx[k] = 1'b0;
      ra[k] = '0; rwd[k] = '0; rr[k] = 1'b0;
    end

    add(1, SZ_WORD, 0, 9'h10, 32'hDEADBEEF, 32'h0, 0);
    add(0, SZ_WORD, 0, 9'h10, 32'h0, 32'hDEADBEEF, 0);
    add(0, SZ_BYTE, 0, 9'h10, 32'h0, 32'h000000DE, 0);
    add(0, SZ_BYTE, 0, 9'h11, 32'h0, 32'h000000AD, 0);
    add(0, SZ_BYTE, 0, 9'h12, 32'h0, 32'h000000BE, 0);
    add(0, SZ_BYTE, 0, 9'h13, 32'h0, 32'h000000EF, 0);
    add(0, SZ_BYTE, 1, 9'h10, 32'h0, 32'hFFFFFFDE, 0);
    add(1, SZ_BYTE, 0, 9'h20, 32'h12345680, 32'h0, 0);
    add(1, SZ_HALF, 0, 9'h22, 32'hABCD8001, 32'h0, 0);
    add(0, SZ_BYTE, 1, 9'h20, 32'h0, 32'hFFFFFF80, 0);
    add(0, SZ_BYTE, 0, 9'h20, 32'h0, 32'h00000080, 0);
    add(0, SZ_HALF, 1, 9'h22, 32'h0, 32'hFFFF8001, 0);
    add(0, SZ_HALF, 0, 9'h22, 32'h0, 32'h00008001, 0);
    add(0, SZ_WORD, 1, 9'h10, 32'h0, 32'hDEADBEEF, 0);
    add(1, SZ_WORD, 0, 9'h30, 32'h0BADF00D, 32'h0, 0);
    add(1, SZ_RSVD, 0, 9'h30, 32'h12345678, 32'h0, 1);
    add(0, SZ_RSVD, 1, 9'h30, 32'h0, 32'h0, 1);
    add(0, SZ_WORD, 0, 9'h30, 32'h0, 32'h0BADF00D, 0);
    add(1, SZ_WORD, 0, 9'h31, 32'h11223344, 32'h0, ALN);
    add(0, SZ_WORD, 0, 9'h30, 32'h0,
        ALN ? 32'h0BADF00D : 32'h0B112233, 0);
    add(0, SZ_WORD, 0, 9'h31, 32'h0, ALN ? 32'h0 : 32'h11223344, ALN);
    add(0, SZ_HALF, 0, 9'h33, 32'h0, ALN ? 32'h0 : 32'h00003344, ALN);
    add(1, SZ_BYTE, 0, 9'd510, 32'h0, 32'h0, 0);
    add(1, SZ_BYTE, 0, 9'd511, 32'h0, 32'h0, 0);
    add(1, SZ_BYTE, 0, 9'd0, 32'h0, 32'h0, 0);
    add(1, SZ_BYTE, 0, 9'd1, 32'h0, 32'h0, 0);
    add(1, SZ_WORD, 0, 9'd510, 32'hA1B2C3D4, 32'h0, ALN);
    add(0, SZ_BYTE, 0, 9'd510, 32'h0, ALN ? 32'h0 : 32'hA1, 0);
    add(0, SZ_BYTE, 0, 9'd511, 32'h0, ALN ? 32'h0 : 32'hB2, 0);
    add(0, SZ_BYTE, 0, 9'd0, 32'h0, ALN ? 32'h0 : 32'hC3, 0);
    add(0, SZ_BYTE, 0, 9'd1, 32'h0, ALN ? 32'h0 : 32'hD4, 0);
    add(0, SZ_HALF, 1, 9'd511, 32'h0, ALN ? 32'h0 : 32'hFFFFB2C3, ALN);
    add(0, SZ_WORD, 0, 9'd510, 32'h0, ALN ? 32'h0 : 32'hA1B2C3D4, ALN);

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_ready", k), 32'(o_ready[k]), 32'd1);
      chk($sformatf("rst%0d_valid", k), 32'(o_valid[k]), 32'd0);
      chk($sformatf("rst%0d_rdata", k), o_rdata[k], 32'd0);
      chk($sformatf("rst%0d_fault", k), 32'(o_fault[k]), 32'd0);
    end

    for (int i = 0; i < nv; i++) begin
      accept(0, tv[i].w, tv[i].sz, tv[i].sx, tv[i].a, tv[i].wd);
      collect(0, rd, ft, lat);
      chk($sformatf("v%0d_rdata", i), rd, tv[i].er);
      chk($sformatf("v%0d_fault", i), 32'(ft), 32'(tv[i].ef));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd1);
    end

    accept(1, 1'b1, SZ_WORD, 1'b0, 9'h40, 32'hCAFEF00D);
    collect(1, rd, ft, lat);
    chk("bp_st_lat", 32'(lat), 32'd3);
    accept(1, 1'b0, SZ_WORD, 1'b0, 9'h40, 32'h0);
    lat = 1;
    while (!o_valid[1] && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk("bp_ld_lat", 32'(lat), 32'd3);
    rv[1] = 1'b1; rw[1] = 1'b1; rsz[1] = SZ_WORD;
    rsx[1] = 1'b0; ra[1] = 9'h40; rwd[1] = 32'h11111111;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_valid", c), 32'(o_valid[1]), 32'd1);
      chk($sformatf("bp%0d_rdata", c), o_rdata[1], 32'hCAFEF00D);
      chk($sformatf("bp%0d_ready", c), 32'(o_ready[1]), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("bp_hold_rdata", o_rdata[1], 32'hCAFEF00D);
    rr[1] = 1'b1;
    @(posedge clk);
    #1;
    rr[1] = 1'b0;
    chk("bp_hs_valid", 32'(o_valid[1]), 32'd0);
    chk("bp_hs_ready", 32'(o_ready[1]), 32'd1);
    @(posedge clk);
    #1;
    rv[1] = 1'b0;
    chk("bp_next_acc", 32'(o_ready[1]), 32'd0);
    collect(1, rd, ft, lat);
    chk("bp_st2_lat", 32'(lat), 32'd3);
    chk("bp_st2_rdata", rd, 32'h0);
    chk("bp_st2_fault", 32'(ft), 32'd0);
    accept(1, 1'b0, SZ_WORD, 1'b0, 9'h40, 32'h0);
    collect(1, rd, ft, lat);
    chk("bp_ld2_rdata", rd, 32'h11111111);

    accept(2, 1'b1, SZ_WORD, 1'b0, 9'h50, 32'h55667788);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mr_valid_async", 32'(o_valid[2]), 32'd0);
    chk("mr_ready_async", 32'(o_ready[2]), 32'd1);
    chk("mr_rdata_async", o_rdata[2], 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    spur = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (o_valid[2]) spur++;
    end
    chk("mr_spurious", 32'(spur), 32'd0);
    chk("mr_ready_after", 32'(o_ready[2]), 32'd1);
    accept(2, 1'b0, SZ_WORD, 1'b0, 9'h50, 32'h0);
    collect(2, rd, ft, lat);
    chk("mr_ld_rdata", rd, 32'h55667788);
    chk("mr_ld_lat", 32'(lat), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
